dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder for the pipelined RISC-V core. It sits at the other end of the core's Memory-stage load/store interface. It accepts one word-addressed request at a time over a valid/ready handshake, inserts a programmable number of wait states, and returns read data or a write completion. While a transaction is in flight it drives `busy`, which the hazard unit uses as a stall source.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the backing array; must be a power of two.
- WAIT_CYCLES, 2: wait states between accept and response; legal range 0..15.
- BASE_ADDR, 32'h0001_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  responder can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables for stores; bit i covers wdata[8i+7:8i]
- rsp_valid  out  1  single-cycle response pulse
- rsp_rdata  out  32  load data; 0 for stores and for errors
- rsp_err  out  1  qualified by rsp_valid; misaligned or out-of-range access
- busy  out  1  transaction in flight; stall request to the hazard unit

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, captured request registers=0. Array contents are not reset.
- Reset mid-transaction: the transaction is dropped and no response is produced. A store not yet committed (state WAIT) never writes.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE); busy = (state!=IDLE).
  - Accept occurs on a rising edge with req_valid && req_ready. On accept, latch we/addr/wdata/be.
  - IDLE→WAIT on accept when WAIT_CYCLES>0, loading counter=WAIT_CYCLES-1.
  - IDLE→RESP on accept when WAIT_CYCLES=0.
  - WAIT: counter decrements each cycle; at counter==0 go to RESP.
  - RESP lasts exactly one cycle, then IDLE.
- Latency: if the accept edge is cycle N, rsp_valid=1 in cycle N+WAIT_CYCLES+1 only.
- Throughput: the next accept is earliest at the edge ending the RESP cycle+1, i.e. one request per WAIT_CYCLES+2 cycles. No request is accepted during RESP.
- Commit: the array write and the read sample happen on the edge entering RESP. rsp_rdata/rsp_err are registered on that same edge and held until the next response or reset.
- Read-after-write: a load always observes every store whose RESP preceded it.
- Error check uses the latched address:
  - err = (addr[1:0]!=0) || ((addr - BASE_ADDR) >= DEPTH_WORDS*4), unsigned 32-bit subtraction, so addresses below BASE wrap to large values and are flagged.
  - On error: no write, rsp_rdata=0, rsp_err=1.
- Index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Stores: only bytes with be=1 change. be=4'b0000 is a legal no-op that still produces a response with err=0. rsp_rdata=0 for stores.
- Loads: full word returned; req_be is ignored.
- No response backpressure: the core must sample rsp_valid in its single cycle.
- req_valid during busy is ignored. The core holds the request until it sees req_ready, and no state is changed by unaccepted requests.
- Request inputs are X-tolerant when req_valid=0.

Test Plan:
- Reset then idle with reset=1 → req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- WAIT_CYCLES=2: store 0xDEADBEEF, be=4'hF, to 0x0001_0004, accepted cycle 0 → busy=1 in cycles 1–3, rsp_valid only in cycle 3 with err=0. Then a load of 0x0001_0004 returns 0xDEADBEEF exactly 3 cycles after its accept.
- Byte enables: store 0x11223344 be=4'b0101 over existing 0xDEADBEEF → subsequent load returns 0xDE22BE44.
- Errors: load 0x0001_0002 → err=1, rdata=0. Store to 0x0000_FFFC and to BASE+DEPTH_WORDS*4 → err=1, and a later load of word 0 and of the last word shows them unchanged.
- WAIT_CYCLES=0: back-to-back requests held valid → accepts every 2 cycles, rsp_valid one cycle after each accept, req_ready=0 during RESP.
- Reset asserted during WAIT of a store of 0xCAFEF00D to 0x0001_0008 (previously 0) → no rsp_valid, outputs 0 immediately (asynchronously), and a later load of 0x0001_0008 returns 0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store bus between the core's Memory stage and the data-memory responder.
//   master : core side. It drives req_* and samples the response and busy.
//   slave  : responder side. It drives req_ready, rsp_* and busy.
//   req_valid/req_ready : request handshake. Accept happens on a clock edge where both are 1.
//   req_we/addr/wdata/be : store flag, byte address, store data, store byte enables.
//   rsp_valid/rdata/err  : single-cycle response pulse, load data, and error flag.
//   busy                 : a transaction is in flight (stall source for the hazard unit).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder. It accepts one word-addressed request at a time,
// inserts WAIT_CYCLES wait states, and then returns a one-cycle response.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : dmem_responder_if.slave (request handshake, response, busy)
// The backing array is not reset. Control and response registers are reset.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
   input  logic              clk,
   input  logic              reset,
   dmem_responder_if.slave   bus
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic          accept, enter_resp;
   logic          c_we;
   logic [31:0]   c_addr, c_wdata, c_off;
   logic [3:0]    c_be;
   logic          c_err;
   logic [AW-1:0] c_idx;
   logic [31:0]   rd_word;

   assign accept = bus.req_valid && (state_q == IDLE);

   // Commit happens on the edge that enters RESP. When there are no wait states,
   // that edge is also the accept edge, so the live bus fields are used because
   // the latched copy is not valid yet. The reset term keeps a held request from
   // writing while reset is asserted.
   assign enter_resp = reset &&
                       (((state_q == WAIT) && (cnt_q == 4'd0)) || (NO_WAIT && accept));

   assign c_we    = NO_WAIT ? bus.req_we    : we_q;
   assign c_addr  = NO_WAIT ? bus.req_addr  : addr_q;
   assign c_wdata = NO_WAIT ? bus.req_wdata : wdata_q;
   assign c_be    = NO_WAIT ? bus.req_be    : be_q;

   // The subtraction is unsigned, so an address below BASE wraps to a large
   // offset and fails the range check.
   assign c_off   = c_addr - BASE_ADDR;
   assign c_err   = (c_addr[1:0] != 2'b00) || (c_off >= SPAN);
   assign c_idx   = c_off[AW+1:2];
   assign rd_word = mem[c_idx];

   always_ff @(posedge clk) begin
      if (enter_resp && c_we && !c_err) begin
         for (int i = 0; i < 4; i++) begin
            if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rsp_valid_d = enter_resp;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               be_d    = bus.req_be;
               if (NO_WAIT) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // The response data and error flag are held until the next response.
      if (enter_resp) begin
         rsp_err_d   = c_err;
         rsp_rdata_d = (c_we || c_err) ? 32'd0 : rd_word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         be_q        <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder.
//   dut_a : WAIT_CYCLES=2, DEPTH_WORDS=1024 (default configuration)
//   dut_b : WAIT_CYCLES=0, DEPTH_WORDS=64
// Both arrays are filled with known data first, so every load has a defined
// expected word in the reference model.
module tb_dmem_responder;
   localparam logic [31:0] BASE = 32'h0001_0000;
   localparam int          DA   = 1024;
   localparam int          DB   = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_responder_if ifa ();
   dmem_responder_if ifb ();

   dmem_responder #(.DEPTH_WORDS(DA), .WAIT_CYCLES(2), .BASE_ADDR(BASE)) u_dut_a (
      .clk(clk), .reset(rst_n), .bus(ifa));
   dmem_responder #(.DEPTH_WORDS(DB), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_dut_b (
      .clk(clk), .reset(rst_n), .bus(ifb));

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl_a [DA];
   logic [31:0] mdl_b [DB];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic rdy(input int s);  return s ? ifb.req_ready : ifa.req_ready; endfunction
   function automatic logic bsy(input int s);  return s ? ifb.busy      : ifa.busy;      endfunction
   function automatic logic vld(input int s);  return s ? ifb.rsp_valid : ifa.rsp_valid; endfunction
   function automatic logic rerr(input int s); return s ? ifb.rsp_err   : ifa.rsp_err;   endfunction
   function automatic logic [31:0] rdat(input int s); return s ? ifb.rsp_rdata : ifa.rsp_rdata; endfunction

   task automatic drive(input int s, input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
      if (s != 0) begin
         ifb.req_valid = v; ifb.req_we = we; ifb.req_addr = a; ifb.req_wdata = wd; ifb.req_be = be;
      end else begin
         ifa.req_valid = v; ifa.req_we = we; ifa.req_addr = a; ifa.req_wdata = wd; ifa.req_be = be;
      end
   endtask

   // Reference model. Each request is an access to a flat word array. It fails
   // if the address is misaligned or lies outside [BASE, BASE + 4*depth).
   task automatic mdl_apply(input int s, input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            output logic [31:0] rd, output logic err);
      int unsigned depth = (s != 0) ? DB : DA;
      logic [31:0] off = a - BASE;
      logic [31:0] w;
      int unsigned idx;
      err = (a % 4 != 0) || (off >= depth * 4);
      rd  = 32'd0;
      if (!err) begin
         idx = off / 4;
         w   = (s != 0) ? mdl_b[idx] : mdl_a[idx];
         if (we) begin
            for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
            if (s != 0) mdl_b[idx] = w; else mdl_a[idx] = w;
         end else begin
            rd = w;
         end
      end
   endtask

   // One complete transaction. It checks the busy/rsp_valid timeline cycle by
   // cycle after the accept, and the response contents.
   task automatic txn(input int s, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd_o, output logic err_o);
      int w = (s != 0) ? 0 : 2;
      int n = 0;
      logic [31:0] exp_rd;
      logic        exp_err;
      rd_o = 32'd0; err_o = 1'b0;
      @(negedge clk);
      drive(s, 1'b1, we, a, wd, be);
      while (!rdy(s) && n < 20) begin @(negedge clk); n++; end
      if (!rdy(s)) begin
         chk("accept_timeout", 32'(rdy(s)), 32'd1);
         drive(s, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
         return;
      end
      @(posedge clk);
      mdl_apply(s, we, a, wd, be, exp_rd, exp_err);
      for (int c = 1; c <= w + 2; c++) begin
         @(negedge clk);
         if (c == 1) drive(s, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
         chk("busy", 32'(bsy(s)), 32'(c <= w + 1));
         chk("rsp_valid", 32'(vld(s)), 32'(c == w + 1));
         if (c == w + 1) begin
            chk("rsp_rdata", rdat(s), exp_rd);
            chk("rsp_err", 32'(rerr(s)), 32'(exp_err));
            rd_o = rdat(s); err_o = rerr(s);
         end
      end
   endtask

   logic [31:0] rd;
   logic        er;
   logic [31:0] ex_rd;
   logic        ex_er;
   logic        b_we [6];
   logic [31:0] b_a  [6];
   logic [31:0] b_wd [6];
   logic [3:0]  b_be [6];

   initial begin
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("rst_ready", 32'(rdy(s)), 32'd1);
         chk("rst_busy", 32'(bsy(s)), 32'd0);
         chk("rst_valid", 32'(vld(s)), 32'd0);
         chk("rst_rdata", rdat(s), 32'd0);
         chk("rst_err", 32'(rerr(s)), 32'd0);
      end

      // Fill both arrays with known data.
      for (int i = 0; i < DA; i++) txn(0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, rd, er);
      for (int i = 0; i < DB; i++) txn(1, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, rd, er);

      // Store followed by a load of the same word, and then a partial-byte merge.
      txn(0, 1'b1, 32'h0001_0004, 32'hDEADBEEF, 4'hF, rd, er);
      chk("st_err", 32'(er), 32'd0);
      txn(0, 1'b0, 32'h0001_0004, 32'd0, 4'h0, rd, er);
      chk("ld_deadbeef", rd, 32'hDEADBEEF);
      txn(0, 1'b1, 32'h0001_0004, 32'h11223344, 4'b0101, rd, er);
      txn(0, 1'b0, 32'h0001_0004, 32'd0, 4'h0, rd, er);
      chk("be_merge", rd, 32'hDE22BE44);
      txn(0, 1'b1, 32'h0001_0004, 32'hFFFF_FFFF, 4'b0000, rd, er);
      chk("be_zero_err", 32'(er), 32'd0);

      // Error cases. None of these may disturb the first or last word.
      txn(0, 1'b0, 32'h0001_0002, 32'd0, 4'h0, rd, er);
      chk("misalign_err", 32'(er), 32'd1);
      chk("misalign_rdata", rd, 32'd0);
      txn(0, 1'b1, 32'h0000_FFFC, 32'h5555_5555, 4'hF, rd, er);
      chk("below_err", 32'(er), 32'd1);
      txn(0, 1'b1, BASE + 32'(DA * 4), 32'hAAAA_AAAA, 4'hF, rd, er);
      chk("above_err", 32'(er), 32'd1);
      txn(0, 1'b0, BASE, 32'd0, 4'h0, rd, er);
      txn(0, 1'b0, BASE + 32'(DA * 4 - 4), 32'd0, 4'h0, rd, er);
      chk("last_ok", 32'(er), 32'd0);

      // Back-to-back requests with the request held valid, no wait states.
      for (int j = 0; j < 6; j++) begin
         b_we[j] = (j % 2 == 0);
         b_a[j]  = BASE + 32'(4 * (j / 2));
         b_wd[j] = $urandom;
         b_be[j] = 4'($urandom);
      end
      b_a[4] = BASE + 32'(DB * 4);
      @(negedge clk);
      drive(1, 1'b1, b_we[0], b_a[0], b_wd[0], b_be[0]);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         chk("b2b_ready", 32'(rdy(1)), 32'(k % 2 == 0));
         chk("b2b_valid", 32'(vld(1)), 32'(k % 2 == 1));
         if (k % 2 == 0) begin
            mdl_apply(1, b_we[k/2], b_a[k/2], b_wd[k/2], b_be[k/2], ex_rd, ex_er);
         end else begin
            chk("b2b_rdata", rdat(1), ex_rd);
            chk("b2b_err", 32'(rerr(1)), 32'(ex_er));
            if (k / 2 < 5) drive(1, 1'b1, b_we[k/2+1], b_a[k/2+1], b_wd[k/2+1], b_be[k/2+1]);
            else           drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
         end
      end

      // Reset during the WAIT phase of a store. The store must never commit.
      txn(0, 1'b1, 32'h0001_0008, 32'd0, 4'hF, rd, er);
      txn(0, 1'b0, 32'h0001_0004, 32'd0, 4'h0, rd, er);
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 32'h0001_0008, 32'hCAFEF00D, 4'hF);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      chk("mid_busy", 32'(bsy(0)), 32'd1);
      chk("held_rdata", rdat(0), 32'hDE22BE44);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(vld(0)), 32'd0);
      chk("arst_rdata", rdat(0), 32'd0);
      chk("arst_err", 32'(rerr(0)), 32'd0);
      chk("arst_busy", 32'(bsy(0)), 32'd0);
      chk("arst_ready", 32'(rdy(0)), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_rst_valid", 32'(vld(0)), 32'd0);
      end
      txn(0, 1'b0, 32'h0001_0008, 32'd0, 4'h0, rd, er);
      chk("dropped_store", rd, 32'd0);

      // Random mix of in-range, misaligned, below-base and above-range accesses.
      for (int i = 0; i < 600; i++) begin
         int s = i % 2;
         int d = (s != 0) ? DB : DA;
         int r = $urandom_range(0, 9);
         logic [31:0] a;
         if (r <= 6)      a = BASE + 32'(4 * $urandom_range(0, d - 1));
         else if (r == 7) a = BASE + 32'(4 * $urandom_range(0, d - 1)) + 32'($urandom_range(1, 3));
         else if (r == 8) a = BASE - 32'(4 * $urandom_range(1, 8));
         else             a = BASE + 32'(d * 4) + 32'(4 * $urandom_range(0, 8));
         txn(s, 1'($urandom), a, $urandom, 4'($urandom), rd, er);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
